// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - parameterised UART transmitter with a small transmit FIFO
module uart_tx_cfg #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [DATA_BITS-1:0]               s_data,
  input  logic                               s_valid,
  output logic                               s_ready,
  output logic                               tx,
  output logic                               busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

  localparam int CPB = CLK_FREQ / BAUD_RATE;
  localparam int BW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int IW  = $clog2(DATA_BITS);

  localparam logic [BW-1:0] BAUD_LAST = BW'(CPB - 1);
  localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic          PAR_ODD   = (PARITY == 2);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;

  logic [2:0]           state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [IW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;

  logic full;
  logic push;
  logic load;
  logic bit_done;

  assign full       = (count_q == DEPTH_C);
  assign s_ready    = !full && !rst;
  assign push       = s_valid && s_ready;
  assign bit_done   = (baud_q == BAUD_LAST);
  assign tx         = tx_q;
  assign busy       = (state_q != S_IDLE) || (count_q != '0);
  assign fifo_count = count_q;

  // FIFO bookkeeping; a full FIFO refuses a push even when a pop happens in the same cycle
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (load) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, load})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Frame sequencer; load pops the head word and starts a new frame on the same edge
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (count_q != '0) load = 1'b1;
      end
      S_START: begin
        if (bit_done) begin
          state_d = S_DATA;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_done) begin
          baud_d = '0;
          if (bit_q == LAST_DATA) begin
            bit_d = '0;
            if (PARITY != 0) begin
              state_d = S_PAR;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_PAR: begin
        if (bit_done) begin
          state_d = S_STOP;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        if (bit_done) begin
          baud_d = '0;
          if (bit_q == LAST_STOP) begin
            bit_d = '0;
            tx_d  = 1'b1;
            if (count_q != '0) load = 1'b1;
            else               state_d = S_IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
        bit_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
    if (load) begin
      state_d = S_START;
      baud_d  = '0;
      bit_d   = '0;
      tx_d    = 1'b0;
      shift_d = mem_q[rd_ptr_q];
      par_d   = (^mem_q[rd_ptr_q]) ^ PAR_ODD;
    end
  end

  // FIFO storage; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s_data;
  end

  // State registers with synchronous reset that aborts any frame and flushes the FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - self-checking bench for uart_tx_cfg over four frame formats
module tb_uart_tx_cfg;

  localparam int NI    = 4;
  localparam int CPB   = 10;
  localparam int DEPTH = 4;

  // instance formats: 8N1, 8E1, 8O1, 7N2
  function int db_of(input int k);
    return (k == 3) ? 7 : 8;
  endfunction
  function int par_of(input int k);
    return (k == 1) ? 1 : (k == 2) ? 2 : 0;
  endfunction
  function int sb_of(input int k);
    return (k == 3) ? 2 : 1;
  endfunction
  function logic [8:0] mask_of(input int k);
    return 9'((1 << db_of(k)) - 1);
  endfunction

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NI-1:0][8:0]   data_v = '0;
  logic [NI-1:0]        valid_v = '0;
  logic [NI-1:0]        ready_v;
  logic [NI-1:0]        tx_v;
  logic [NI-1:0]        busy_v;
  logic [NI-1:0][2:0]   count_v;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    uart_tx_cfg #(
      .CLK_FREQ  (100_000_000),
      .BAUD_RATE (10_000_000),
      .DATA_BITS (db_of(g)),
      .PARITY    (par_of(g)),
      .STOP_BITS (sb_of(g)),
      .FIFO_DEPTH(DEPTH)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .s_data    (data_v[g][db_of(g)-1:0]),
      .s_valid   (valid_v[g]),
      .s_ready   (ready_v[g]),
      .tx        (tx_v[g]),
      .busy      (busy_v[g]),
      .fifo_count(count_v[g])
    );
  end

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // reference model: words waiting in the buffer, and the line level for every future cycle
  logic [8:0] wq [NI][$];
  bit         bq [NI][$];
  logic [NI-1:0] e_tx, e_busy, acc;
  int            e_cnt [NI];

  task automatic append_frame(input int k, input logic [8:0] w);
    bit p;
    p = ^(w & mask_of(k));
    if (par_of(k) == 2) p = !p;
    repeat (CPB) bq[k].push_back(1'b0);
    for (int b = 0; b < db_of(k); b++) repeat (CPB) bq[k].push_back(w[b]);
    if (par_of(k) != 0) repeat (CPB) bq[k].push_back(p);
    repeat (sb_of(k) * CPB) bq[k].push_back(1'b1);
  endtask

  // one clock: model follows the rising edge, outputs are then observed on the falling edge
  task automatic advance();
    bit took;
    @(posedge clk);
    cyc++;
    for (int k = 0; k < NI; k++) begin
      if (rst) begin
        wq[k].delete();
        bq[k].delete();
        acc[k]    = 1'b0;
        e_tx[k]   = 1'b1;
        e_busy[k] = 1'b0;
        e_cnt[k]  = 0;
      end else begin
        acc[k] = valid_v[k] && (wq[k].size() < DEPTH);
        if (bq[k].size() == 0 && wq[k].size() > 0) append_frame(k, wq[k].pop_front());
        if (acc[k]) wq[k].push_back(data_v[k] & mask_of(k));
        took = 1'b0;
        if (bq[k].size() > 0) begin
          e_tx[k] = bq[k].pop_front();
          took = 1'b1;
        end else begin
          e_tx[k] = 1'b1;
        end
        e_busy[k] = took || (wq[k].size() != 0);
        e_cnt[k]  = wq[k].size();
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    valid_v = '0;
    repeat (3) advance();
    for (int k = 0; k < NI; k++) begin
      vectors += 4;
      if (tx_v[k] !== 1'b1) begin miscompares++; $display("FAIL reset_tx inst %0d got %b expected 1", k, tx_v[k]); end
      if (busy_v[k] !== 1'b0) begin miscompares++; $display("FAIL reset_busy inst %0d got %b expected 0", k, busy_v[k]); end
      if (count_v[k] !== 3'd0) begin miscompares++; $display("FAIL reset_count inst %0d got %0d expected 0", k, count_v[k]); end
      if (ready_v[k] !== 1'b0) begin miscompares++; $display("FAIL reset_ready inst %0d got %b expected 0", k, ready_v[k]); end
    end
    rst = 1'b0;
    advance();
    for (int k = 0; k < NI; k++) begin
      vectors += 2;
      if (ready_v[k] !== 1'b1) begin miscompares++; $display("FAIL first_ready inst %0d got %b expected 1", k, ready_v[k]); end
      if (tx_v[k] !== 1'b1) begin miscompares++; $display("FAIL idle_tx inst %0d got %b expected 1", k, tx_v[k]); end
    end
  endtask

  task automatic test_frames();
    logic [9:0] got0;
    logic par1, par2, t3_99, t3_100;
    got0 = '0; par1 = 1'b0; par2 = 1'b1; t3_99 = 1'b0; t3_100 = 1'b1;
    data_v[0] = 9'h0A5; data_v[1] = 9'h007; data_v[2] = 9'h007; data_v[3] = 9'h055;
    valid_v = '1;
    advance();
    valid_v = 4'b1000;
    data_v[3] = 9'h02A;
    for (int j = 0; j < 240; j++) begin
      advance();
      if (j == 0) valid_v = '0;
      for (int k = 0; k < NI; k++) begin
        vectors += 3;
        if (tx_v[k] !== e_tx[k]) begin miscompares++; $display("FAIL frame_tx inst %0d cycle %0d got %b expected %b", k, cyc, tx_v[k], e_tx[k]); end
        if (busy_v[k] !== e_busy[k]) begin miscompares++; $display("FAIL frame_busy inst %0d cycle %0d got %b expected %b", k, cyc, busy_v[k], e_busy[k]); end
        if (count_v[k] !== 3'(e_cnt[k])) begin miscompares++; $display("FAIL frame_count inst %0d cycle %0d got %0d expected %0d", k, cyc, count_v[k], e_cnt[k]); end
      end
      if (j < 100 && j % 10 == 5) got0[j / 10] = tx_v[0];
      if (j == 95) begin par1 = tx_v[1]; par2 = tx_v[2]; end
      if (j == 99) t3_99 = tx_v[3];
      if (j == 100) t3_100 = tx_v[3];
    end
    vectors += 5;
    if (got0 !== 10'b1101001010) begin miscompares++; $display("FAIL a5_bits got %b expected %b", got0, 10'b1101001010); end
    if (par1 !== 1'b1) begin miscompares++; $display("FAIL even_parity got %b expected 1", par1); end
    if (par2 !== 1'b0) begin miscompares++; $display("FAIL odd_parity got %b expected 0", par2); end
    if (t3_99 !== 1'b1) begin miscompares++; $display("FAIL 7n2_stop_end got %b expected 1", t3_99); end
    if (t3_100 !== 1'b0) begin miscompares++; $display("FAIL 7n2_second_start got %b expected 0", t3_100); end
  endtask

  task automatic test_back_to_back();
    logic [8:0] base [NI];
    for (int k = 0; k < NI; k++) base[k] = 9'($urandom);
    valid_v = '1;
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < NI; k++) data_v[k] = 9'(base[k] + 9'(i * 37));
      advance();
      for (int k = 0; k < NI; k++) begin
        vectors += 2;
        if (count_v[k] !== 3'(e_cnt[k])) begin miscompares++; $display("FAIL b2b_count inst %0d cycle %0d got %0d expected %0d", k, cyc, count_v[k], e_cnt[k]); end
        if (ready_v[k] !== (e_cnt[k] < DEPTH)) begin miscompares++; $display("FAIL b2b_ready inst %0d cycle %0d got %b expected %b", k, cyc, ready_v[k], e_cnt[k] < DEPTH); end
      end
    end
    for (int k = 0; k < NI; k++) begin
      vectors += 2;
      if (count_v[k] !== 3'd4) begin miscompares++; $display("FAIL b2b_full_count inst %0d got %0d expected 4", k, count_v[k]); end
      if (ready_v[k] !== 1'b0) begin miscompares++; $display("FAIL b2b_full_ready inst %0d got %b expected 0", k, ready_v[k]); end
    end
    valid_v = '0;
    for (int j = 0; j < 700; j++) begin
      advance();
      for (int k = 0; k < NI; k++) begin
        vectors += 3;
        if (tx_v[k] !== e_tx[k]) begin miscompares++; $display("FAIL b2b_tx inst %0d cycle %0d got %b expected %b", k, cyc, tx_v[k], e_tx[k]); end
        if (busy_v[k] !== e_busy[k]) begin miscompares++; $display("FAIL b2b_busy inst %0d cycle %0d got %b expected %b", k, cyc, busy_v[k], e_busy[k]); end
        if (count_v[k] !== 3'(e_cnt[k])) begin miscompares++; $display("FAIL b2b_drain_count inst %0d cycle %0d got %0d expected %0d", k, cyc, count_v[k], e_cnt[k]); end
      end
    end
  endtask

  task automatic test_random();
    for (int j = 0; j < 3100; j++) begin
      for (int k = 0; k < NI; k++) begin
        valid_v[k] = (j < 2500) && ($urandom_range(0, 3) == 0);
        data_v[k]  = 9'($urandom);
      end
      advance();
      for (int k = 0; k < NI; k++) begin
        vectors += 4;
        if (tx_v[k] !== e_tx[k]) begin miscompares++; $display("FAIL rnd_tx inst %0d cycle %0d got %b expected %b", k, cyc, tx_v[k], e_tx[k]); end
        if (busy_v[k] !== e_busy[k]) begin miscompares++; $display("FAIL rnd_busy inst %0d cycle %0d got %b expected %b", k, cyc, busy_v[k], e_busy[k]); end
        if (count_v[k] !== 3'(e_cnt[k])) begin miscompares++; $display("FAIL rnd_count inst %0d cycle %0d got %0d expected %0d", k, cyc, count_v[k], e_cnt[k]); end
        if (ready_v[k] !== (e_cnt[k] < DEPTH)) begin miscompares++; $display("FAIL rnd_ready inst %0d cycle %0d got %b expected %b", k, cyc, ready_v[k], e_cnt[k] < DEPTH); end
      end
    end
    valid_v = '0;
  endtask

  task automatic test_reset_midframe();
    valid_v = '1;
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < NI; k++) data_v[k] = 9'($urandom);
      advance();
    end
    valid_v = '0;
    for (int j = 2; j < 35; j++) begin
      advance();
      for (int k = 0; k < NI; k++) begin
        vectors += 2;
        if (tx_v[k] !== e_tx[k]) begin miscompares++; $display("FAIL pre_rst_tx inst %0d cycle %0d got %b expected %b", k, cyc, tx_v[k], e_tx[k]); end
        if (count_v[k] !== 3'(e_cnt[k])) begin miscompares++; $display("FAIL pre_rst_count inst %0d cycle %0d got %0d expected %0d", k, cyc, count_v[k], e_cnt[k]); end
      end
    end
    rst = 1'b1;
    advance();
    for (int k = 0; k < NI; k++) begin
      vectors += 4;
      if (tx_v[k] !== 1'b1) begin miscompares++; $display("FAIL midrst_tx inst %0d got %b expected 1", k, tx_v[k]); end
      if (count_v[k] !== 3'd0) begin miscompares++; $display("FAIL midrst_count inst %0d got %0d expected 0", k, count_v[k]); end
      if (busy_v[k] !== 1'b0) begin miscompares++; $display("FAIL midrst_busy inst %0d got %b expected 0", k, busy_v[k]); end
      if (ready_v[k] !== 1'b0) begin miscompares++; $display("FAIL midrst_ready inst %0d got %b expected 0", k, ready_v[k]); end
    end
    advance();
    rst = 1'b0;
    for (int k = 0; k < NI; k++) data_v[k] = 9'h03C;
    valid_v = '1;
    advance();
    valid_v = '0;
    for (int j = 0; j < 130; j++) begin
      advance();
      for (int k = 0; k < NI; k++) begin
        vectors += 3;
        if (tx_v[k] !== e_tx[k]) begin miscompares++; $display("FAIL post_rst_tx inst %0d cycle %0d got %b expected %b", k, cyc, tx_v[k], e_tx[k]); end
        if (busy_v[k] !== e_busy[k]) begin miscompares++; $display("FAIL post_rst_busy inst %0d cycle %0d got %b expected %b", k, cyc, busy_v[k], e_busy[k]); end
        if (count_v[k] !== 3'(e_cnt[k])) begin miscompares++; $display("FAIL post_rst_count inst %0d cycle %0d got %0d expected %0d", k, cyc, count_v[k], e_cnt[k]); end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cycle %0d got timeout expected completion", cyc);
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_frames();
    test_back_to_back();
    test_random();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, line bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer division), legal only if >= 2.
REQ-003 SHALL have parameter DATA_BITS, default 8, payload width, legal range 5..9.
REQ-004 SHALL have parameter PARITY, default 0; 0 = none, 1 = even, 2 = odd.
REQ-005 SHALL have parameter STOP_BITS, default 1, legal values 1 or 2.
REQ-006 SHALL have parameter FIFO_DEPTH, default 4, transmit buffer entries; power of 2, >= 2.
REQ-007 SHALL use one clock and a synchronous, active-high reset: clk clocks all state; rst high at a rising edge resets the block.
REQ-008 clk  input  1  system clock, all state on the rising edge.
REQ-009 rst  input  1  synchronous active-high reset.
REQ-010 s_data  input  DATA_BITS  word to transmit.
REQ-011 s_valid  input  1  s_data is valid.
REQ-012 s_ready  output  1  FIFO can accept a word; = !full && !rst (combinational).
REQ-013 tx  output  1  registered serial line; idles high.
REQ-014 busy  output  1  = (FSM != IDLE) || (fifo_count != 0).
REQ-015 fifo_count  output  clog2(FIFO_DEPTH+1)  words currently buffered.

Function
REQ-016 A word SHALL be written into the FIFO on each rising edge where s_valid && s_ready; s_data is sampled at that edge only.
REQ-017 When full, s_ready SHALL be 0 even if a pop occurs in the same cycle; no word is ever dropped or overwritten.
REQ-018 A push and a pop in the same cycle SHALL leave fifo_count unchanged. Pointers SHALL wrap modulo FIFO_DEPTH.
REQ-019 The FSM SHALL have the states IDLE, START, DATA, PAR and STOP.
REQ-020 In IDLE with fifo_count != 0, the FSM SHALL pop the head word into a shift register on the next edge, drive tx <= 0 on that edge and enter START.
REQ-021 Latency: a word accepted at edge E0 into an empty, idle block SHALL drive tx low from edge E0+1.
REQ-022 START SHALL last CLKS_PER_BIT cycles. DATA SHALL send DATA_BITS bits LSB first, each for CLKS_PER_BIT cycles.
REQ-023 PAR SHALL be entered only when PARITY != 0 and SHALL last CLKS_PER_BIT cycles.
REQ-024 The parity bit SHALL be the XOR of the data bits when PARITY = 1, and the inverted XOR when PARITY = 2.
REQ-025 STOP SHALL drive tx = 1 for STOP_BITS*CLKS_PER_BIT cycles.
REQ-026 At the end of STOP, if fifo_count != 0, the FSM SHALL pop and enter START on the same edge (no idle cycle between frames); otherwise it SHALL enter IDLE.
REQ-027 The baud counter SHALL be clog2(CLKS_PER_BIT) bits wide, SHALL restart at 0 on every state/bit change, and SHALL never exceed CLKS_PER_BIT-1.
REQ-028 Frame length SHALL be exactly (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * CLKS_PER_BIT cycles.
REQ-029 Changes on s_data or s_valid during a frame SHALL NOT affect the frame in progress.
REQ-030 Any unused or illegal FSM encoding SHALL return to IDLE with tx = 1 on the next edge.

Reset
REQ-031 While rst is sampled high: FSM = IDLE, tx = 1, fifo_count = 0, pointers = 0, baud counter = 0, bit index = 0, busy = 0, s_ready = 0.
REQ-032 Reset mid-frame SHALL abort the frame and flush the FIFO; tx SHALL be 1 from the reset edge onward.
REQ-033 On the first edge with rst low, s_ready SHALL be 1.

Verification (CLK_FREQ = 100_000_000, BAUD_RATE = 10_000_000, so CLKS_PER_BIT = 10)
REQ-034 Defaults (8N1); push 0xA5 -> tx = 0,1,0,1,0,0,1,0,1,1, each level held 10 cycles; tx first low one cycle after accept; busy high for 100 cycles, then 0.
REQ-035 PARITY = 1, push 0x07 -> parity bit = 1, frame 110 cycles; with PARITY = 2 -> parity bit = 0.
REQ-036 FIFO_DEPTH = 4, s_valid held high with 6 distinct words -> 5 accepted (first popped immediately); s_ready falls when fifo_count = 4; frames emitted back-to-back with no idle gap, in push order.
REQ-037 DATA_BITS = 7, STOP_BITS = 2, push two words -> second start bit begins exactly 100 cycles after the first; MSB is bit 6.
REQ-038 Assert rst at cycle 35 of a frame with 2 words queued -> tx = 1 and fifo_count = 0 from the reset edge; a new word 0x3C after reset transmits correctly.
REQ-039 Push with s_ready = 0 (FIFO full) -> word not stored, fifo_count unchanged, no extra frame transmitted.
